// File: rtl/risc_boot_pkg.sv
// Shared types and constants for the RISC boot/run sequencer.
package risc_boot_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;
   localparam int CYC_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HOLD = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4,
      ST_TMO  = 3'd5
   } boot_state_e;

   // States in which the load stream may be accepted.
   function automatic logic accepts_words(input boot_state_e s);
      return (s == ST_IDLE) || (s == ST_LOAD);
   endfunction

endpackage

// File: rtl/risc_boot_ctrl_sat_counter.sv
// Width-parameterised up-counter with synchronous clear, enable,
// saturation at MAX and a terminal-count flag at TERM.
module sat_counter
   import risc_boot_pkg::*;
#(
   parameter int             W    = CYC_W,
   parameter logic [W-1:0]   TERM = {W{1'b1}},
   parameter logic [W-1:0]   MAX  = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_r;

   // Count register: reset and clear first, then increment unless saturated.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (en && (cnt_r != MAX)) begin
         cnt_r <= cnt_r + W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
   assign tc  = (cnt_r == TERM);

endmodule

// File: rtl/risc_boot_ctrl.sv
// Boot and run sequencer: streams an image into the core's memory,
// holds the core in reset, releases it and supervises it with a budget.
module risc_boot_ctrl
   import risc_boot_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int RST_HOLD = 9,
   parameter int TIMEOUT  = 4096
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [AW-1:0]    ld_addr,
   input  logic [DW-1:0]    ld_data,
   input  logic             ld_last,
   input  logic             start,
   input  logic             clear,
   output logic             ext_we,
   output logic [AW-1:0]    ext_addr,
   output logic [DW-1:0]    ext_data,
   output logic             test_normal,
   output logic             cpu_reset_n,
   input  logic             cpu_done,
   input  logic [DW-1:0]    cpu_out,
   output logic             busy,
   output logic             run_done,
   output logic             timeout,
   output logic [CYC_W-1:0] cycles,
   output logic [DW-1:0]    result
);

   localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [CYC_W-1:0]  RUN_LAST  = CYC_W'(TIMEOUT - 1);

   boot_state_e       state_r;
   boot_state_e       next_state_s;
   logic              accept_s;
   logic              hold_clr_s;
   logic              hold_en_s;
   logic              hold_tc_s;
   logic [HOLD_W-1:0] hold_cnt_s;
   logic              run_clr_s;
   logic              run_en_s;
   logic              run_tc_s;
   logic [CYC_W-1:0]  cycles_s;

   logic              ld_ready_r;
   logic              ext_we_r;
   logic [AW-1:0]     ext_addr_r;
   logic [DW-1:0]     ext_data_r;
   logic              test_normal_r;
   logic              cpu_reset_n_r;
   logic              busy_r;
   logic              run_done_r;
   logic              timeout_r;
   logic [DW-1:0]     result_r;

   // Hold counter: runs only in HOLD, zero on the first HOLD cycle.
   sat_counter #(
      .W    (HOLD_W),
      .TERM (HOLD_LAST),
      .MAX  ({HOLD_W{1'b1}})
   ) u_hold_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (hold_clr_s),
      .en      (hold_en_s),
      .cnt     (hold_cnt_s),
      .tc      (hold_tc_s)
   );

   // RUN cycle counter: cleared on HOLD entry, saturates at all-ones;
   // terminal count marks the last RUN cycle within the budget.
   sat_counter #(
      .W    (CYC_W),
      .TERM (RUN_LAST),
      .MAX  ({CYC_W{1'b1}})
   ) u_run_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (run_clr_s),
      .en      (run_en_s),
      .cnt     (cycles_s),
      .tc      (run_tc_s)
   );

   // Next-state decode; clear overrides everything and blocks acceptance.
   always_comb begin
      next_state_s = state_r;
      accept_s     = ld_valid & ld_ready_r & ~clear;
      if (clear) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  next_state_s = ld_last ? ST_HOLD : ST_LOAD;
               end else if (start) begin
                  next_state_s = ST_HOLD;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (accept_s && ld_last) begin
                  next_state_s = ST_HOLD;
               end else begin
                  next_state_s = ST_LOAD;
               end
            end
            ST_HOLD: begin
               if (hold_tc_s) begin
                  next_state_s = ST_RUN;
               end else begin
                  next_state_s = ST_HOLD;
               end
            end
            ST_RUN: begin
               if (cpu_done) begin
                  next_state_s = ST_DONE;
               end else if (run_tc_s) begin
                  next_state_s = ST_TMO;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
            ST_DONE: next_state_s = ST_DONE;
            ST_TMO:  next_state_s = ST_TMO;
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   // Counter controls; the hold counter also freezes at its terminal value.
   always_comb begin
      hold_clr_s = (state_r != ST_HOLD);
      hold_en_s  = (state_r == ST_HOLD) && (hold_cnt_s != HOLD_LAST);
      run_clr_s  = (next_state_s == ST_HOLD);
      run_en_s   = (state_r == ST_RUN) && !clear;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Registered outputs, derived from the state being entered so they
   // line up with it; test_normal stays high through the final write.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ld_ready_r    <= 1'b1;
         ext_we_r      <= 1'b0;
         ext_addr_r    <= {AW{1'b0}};
         ext_data_r    <= {DW{1'b0}};
         test_normal_r <= 1'b1;
         cpu_reset_n_r <= 1'b0;
         busy_r        <= 1'b0;
         run_done_r    <= 1'b0;
         timeout_r     <= 1'b0;
         result_r      <= {DW{1'b0}};
      end else begin
         ld_ready_r    <= accepts_words(next_state_s);
         ext_we_r      <= accept_s;
         if (accept_s) begin
            ext_addr_r <= ld_addr;
            ext_data_r <= ld_data;
         end
         test_normal_r <= accept_s | accepts_words(next_state_s);
         cpu_reset_n_r <= (next_state_s == ST_RUN) || (next_state_s == ST_DONE);
         busy_r        <= (next_state_s == ST_LOAD) || (next_state_s == ST_HOLD) ||
                          (next_state_s == ST_RUN);
         run_done_r    <= (next_state_s == ST_DONE);
         timeout_r     <= (next_state_s == ST_TMO);
         if (run_clr_s) begin
            result_r <= {DW{1'b0}};
         end else if ((state_r == ST_RUN) && cpu_done && !clear) begin
            result_r <= cpu_out;
         end
      end
   end

   assign ld_ready    = ld_ready_r;
   assign ext_we      = ext_we_r;
   assign ext_addr    = ext_addr_r;
   assign ext_data    = ext_data_r;
   assign test_normal = test_normal_r;
   assign cpu_reset_n = cpu_reset_n_r;
   assign busy        = busy_r;
   assign run_done    = run_done_r;
   assign timeout     = timeout_r;
   assign cycles      = cycles_s;
   assign result      = result_r;

endmodule

// File: tb/tb_risc_boot_ctrl.sv
// Randomised bench for risc_boot_ctrl against a behavioural model.
module tb_risc_boot_ctrl;

   localparam int AW       = 16;
   localparam int DW       = 16;
   localparam int RST_HOLD = 9;
   localparam int TIMEOUT  = 8;

   logic          clk = 1'b0;
   logic          reset_n, ld_valid, ld_last, start, clear, cpu_done;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data, cpu_out;
   logic          ld_ready, ext_we, test_normal, cpu_reset_n, busy, run_done, timeout;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_data, result;
   logic [15:0]   cycles;

   risc_boot_ctrl #(.AW(AW), .DW(DW), .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .start(start),
      .clear(clear), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
      .test_normal(test_normal), .cpu_reset_n(cpu_reset_n), .cpu_done(cpu_done),
      .cpu_out(cpu_out), .busy(busy), .run_done(run_done), .timeout(timeout),
      .cycles(cycles), .result(result)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase of operation plus remaining hold time.
   typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_DONE, M_TMO} mode_t;
   mode_t         mode = M_IDLE;
   int            hold_left = 0;
   int            run_cnt = 0;
   logic [DW-1:0] m_result = '0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_tn = 1'b1;
   int            n_we = 0;
   int            chk_cnt = 0;
   int            err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic enter_hold();
      mode      = M_HOLD;
      hold_left = RST_HOLD;
      run_cnt   = 0;
      m_result  = '0;
   endtask

   // Apply the rules of operation to the inputs seen at a rising edge.
   task automatic model_edge();
      logic acc;
      if (!reset_n) begin
         mode = M_IDLE; hold_left = 0; run_cnt = 0; m_result = '0;
         m_we = 1'b0; m_addr = '0; m_data = '0; m_tn = 1'b1;
      end else begin
         acc  = ld_valid && (mode == M_IDLE || mode == M_LOAD) && !clear;
         m_we = acc;
         if (acc) begin
            m_addr = ld_addr;
            m_data = ld_data;
         end
         if (clear) begin
            mode = M_IDLE;
         end else begin
            case (mode)
               M_IDLE: if (acc) begin
                          if (ld_last) enter_hold(); else mode = M_LOAD;
                       end else if (start) enter_hold();
               M_LOAD: if (acc && ld_last) enter_hold();
               M_HOLD: begin
                  hold_left--;
                  if (hold_left == 0) mode = M_RUN;
               end
               M_RUN: begin
                  if (run_cnt < 65535) run_cnt++;
                  if (cpu_done) begin
                     mode = M_DONE;
                     m_result = cpu_out;
                  end else if (run_cnt == TIMEOUT) begin
                     mode = M_TMO;
                  end
               end
               default: ;
            endcase
         end
         m_tn = acc || mode == M_IDLE || mode == M_LOAD;
      end
   endtask

   task automatic compare_all();
      check("ld_ready",    32'(ld_ready),    32'(mode == M_IDLE || mode == M_LOAD));
      check("ext_we",      32'(ext_we),      32'(m_we));
      if (m_we) begin
         check("ext_addr", 32'(ext_addr),    32'(m_addr));
         check("ext_data", 32'(ext_data),    32'(m_data));
      end
      check("test_normal", 32'(test_normal), 32'(m_tn));
      check("cpu_reset_n", 32'(cpu_reset_n), 32'(mode == M_RUN || mode == M_DONE));
      check("busy",        32'(busy),        32'(mode == M_LOAD || mode == M_HOLD || mode == M_RUN));
      check("run_done",    32'(run_done),    32'(mode == M_DONE));
      check("timeout",     32'(timeout),     32'(mode == M_TMO));
      check("cycles",      32'(cycles),      32'(run_cnt));
      check("result",      32'(result),      32'(m_result));
      if (ext_we === 1'b1) n_we++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0; clear = 1'b0; cpu_done = 1'b0;
      ld_addr = AW'($urandom); ld_data = DW'($urandom); cpu_out = DW'($urandom);
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic last, input int gap, input logic with_start);
      for (int g = 0; g < gap; g++) begin
         ld_valid = 1'b0; ld_addr = AW'($urandom); ld_data = DW'($urandom);
         ld_last = 1'($urandom_range(0, 1));
         step();
      end
      ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last; start = with_start;
      step();
      ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_phase(input int k, input logic [DW-1:0] val);
      int guard;
      guard = 0;
      while (mode == M_HOLD && guard < 4 * RST_HOLD) begin
         cpu_done = 1'($urandom_range(0, 1)); cpu_out = DW'($urandom);
         step();
         guard++;
      end
      cpu_done = 1'b0;
      for (int i = 0; i < k && mode == M_RUN; i++) begin
         cpu_out = DW'($urandom);
         step();
      end
      if (mode == M_RUN) begin
         cpu_done = 1'b1; cpu_out = val;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         cpu_done = 1'($urandom_range(0, 1)); cpu_out = DW'($urandom);
         step();
      end
      cpu_done = 1'b0;
   endtask

   task automatic clear_pulse(input logic offer);
      clear = 1'b1; ld_valid = offer; ld_addr = AW'($urandom); ld_data = DW'($urandom);
      ld_last = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      step();
      clear = 1'b0; ld_valid = 1'b0; start = 1'b0; ld_last = 1'b0;
      check("clr_we",    32'(ext_we),      32'(1'b0));
      check("clr_rstn",  32'(cpu_reset_n), 32'(1'b0));
      check("clr_ready", 32'(ld_ready),    32'(1'b1));
   endtask

   initial begin
      int we0, n, guard;
      logic [DW-1:0] v;
      reset_n = 1'b0;
      idle_inputs();
      step();
      step();
      check("rst_addr",   32'(ext_addr),    32'h0);
      check("rst_data",   32'(ext_data),    32'h0);
      check("rst_tn",     32'(test_normal), 32'h1);
      check("rst_ready",  32'(ld_ready),    32'h1);
      reset_n = 1'b1;
      step();

      // Bench program image: 12 words at 0x0..0xB plus two data words.
      we0 = n_we;
      for (int i = 0; i < 12; i++) load_word(AW'(i), DW'($urandom), 1'b0, 0, 1'b0);
      load_word(AW'(16'h25), DW'(16'h0047), 1'b0, 0, 1'b0);
      load_word(AW'(16'h26), DW'(16'h0089), 1'b1, 0, 1'b0);
      run_phase($urandom_range(0, 6), 16'hFFBE);
      check("plan_writes", 32'(n_we - we0), 32'd14);
      check("plan_done",   32'(run_done),   32'h1);
      check("plan_result", 32'(result),     32'h0000FFBE);
      clear_pulse(1'b1);

      // Gapped load with start pulses offered alongside every word.
      we0 = n_we;
      for (int i = 0; i < 6; i++)
         load_word(AW'($urandom), DW'($urandom), 1'(i == 5), 1, 1'b1);
      check("gap_writes", 32'(n_we - we0), 32'd6);
      run_phase(2, DW'($urandom));
      clear_pulse(1'b0);

      // Start with no image, then run out of budget.
      start_pulse();
      run_phase(20, DW'($urandom));
      check("tmo_flag",   32'(timeout),     32'h1);
      check("tmo_cycles", 32'(cycles),      32'(TIMEOUT));
      check("tmo_rstn",   32'(cpu_reset_n), 32'h0);
      clear_pulse(1'b1);

      // Halt in the last budgeted cycle wins over timeout.
      v = DW'($urandom);
      start_pulse();
      run_phase(TIMEOUT - 1, v);
      check("last_done",   32'(run_done), 32'h1);
      check("last_cycles", 32'(cycles),   32'(TIMEOUT));
      check("last_result", 32'(result),   32'(v));
      clear_pulse(1'b0);

      // Reset in the middle of RUN.
      start_pulse();
      guard = 0;
      while (mode != M_RUN && guard < 4 * RST_HOLD) begin step(); guard++; end
      check("reach_run", 32'(mode == M_RUN), 32'h1);
      step();
      step();
      reset_n = 1'b0;
      step();
      check("mid_rst_cycles", 32'(cycles),      32'h0);
      check("mid_rst_busy",   32'(busy),        32'h0);
      check("mid_rst_rstn",   32'(cpu_reset_n), 32'h0);
      reset_n = 1'b1;
      step();

      // Mixed random traffic including clears in LOAD, HOLD and RUN.
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               n = $urandom_range(1, 5);
               for (int i = 0; i < n; i++)
                  load_word(AW'($urandom), DW'($urandom), 1'(i == n - 1),
                            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
               run_phase($urandom_range(0, 10), DW'($urandom));
               clear_pulse(1'($urandom_range(0, 1)));
            end
            1: begin
               start_pulse();
               run_phase($urandom_range(0, 10), DW'($urandom));
               if ($urandom_range(0, 1) == 1) clear_pulse(1'b1); else clear_pulse(1'b0);
            end
            2: begin
               n = $urandom_range(1, 4);
               for (int i = 0; i < n; i++)
                  load_word(AW'($urandom), DW'($urandom), 1'b0, $urandom_range(0, 1), 1'b0);
               clear_pulse(1'b1);
            end
            default: begin
               start_pulse();
               for (int i = 0; i < $urandom_range(0, RST_HOLD + 4); i++) step();
               clear_pulse(1'($urandom_range(0, 1)));
            end
         endcase
         step();
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/risc_boot_ctrl.md
# risc_boot_ctrl

Boot and run sequencer for the RISC core and its dual-port memory. Accepts a program/data image as a stream of address/data words and writes it through the memory's external port. It then holds the core in reset for a fixed interval, releases it, and watches `done` with a cycle budget. It sits between the host/bench side and `RISC_complete`, driving that block's `ext_we`, `ext_addr`, `ext_data`, `test_normal` and reset inputs.

## Interface
Parameters:
- `AW`, 16, memory address width
- `DW`, 16, memory data width
- `RST_HOLD`, 9, cycles the core is held in reset before release (≥1)
- `TIMEOUT`, 4096, maximum RUN cycles before abort (≥1, ≤ 2^16−1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `ld_valid`  in  1  load word valid
- `ld_ready`  out  1  load word accepted when high with `ld_valid`
- `ld_addr`  in  AW  load address
- `ld_data`  in  DW  load data
- `ld_last`  in  1  marks final word of image
- `start`  in  1  pulse: run the already-loaded image (IDLE only)
- `clear`  in  1  pulse: abort and return to IDLE from any state
- `ext_we`  out  1  memory external write enable
- `ext_addr`  out  AW  memory external address
- `ext_data`  out  DW  memory external write data
- `test_normal`  out  1  1 = external port owns memory, 0 = core owns it
- `cpu_reset_n`  out  1  core reset, active-low
- `cpu_done`  in  1  core halted (HLT executed)
- `cpu_out`  in  DW  core output register (OutR)
- `busy`  out  1  high in LOAD, HOLD, RUN
- `run_done`  out  1  high in DONE
- `timeout`  out  1  high in TMO
- `cycles`  out  16  RUN cycle count
- `result`  out  DW  `cpu_out` captured at `cpu_done`

## Operation
- States: IDLE, LOAD, HOLD, RUN, DONE, TMO.
- IDLE:
  - `ld_ready`=1, `test_normal`=1, `cpu_reset_n`=0.
  - Accepted word → LOAD, or → HOLD if `ld_last`.
  - `start` without `ld_valid` → HOLD.
  - `ld_valid` and `start` together: load wins and `start` is ignored.
- LOAD:
  - `ld_ready`=1; each accepted word is written to memory.
  - Accepted word with `ld_last` → HOLD.
  - `start` is ignored.
- HOLD:
  - `ld_ready`=0, `test_normal`=0, `cpu_reset_n`=0.
  - Hold counter counts `RST_HOLD` cycles, then → RUN.
  - `cycles` and `result` are cleared on HOLD entry.
- RUN:
  - `cpu_reset_n`=1; `cycles` increments each RUN cycle.
  - `cpu_done` sampled high → DONE, capturing `result`←`cpu_out`.
  - `cycles` reaching `TIMEOUT` without `cpu_done` → TMO.
  - If `cpu_done` and timeout coincide, DONE wins.
- DONE: `cpu_reset_n` stays 1 (core remains halted, `OutR` observable); wait for `clear`.
- TMO: `cpu_reset_n`=0; wait for `clear`.
- `clear`:
  - Highest priority in every state; → IDLE next cycle.
  - `ext_we` forced 0 and `cpu_reset_n` driven 0 the same edge.
  - A word offered in the same cycle as `clear` is not accepted.
- `ld_*` inputs are ignored when `ld_ready`=0. Source must hold them stable until accepted.
- `cycles` saturates at 16'hFFFF and never wraps.

## Timing
- All outputs are registered. On reset (`reset_n`=0 at a rising edge), all outputs take their reset values next cycle:
  - `ext_we`=0, `ext_addr`=0, `ext_data`=0
  - `test_normal`=1, `cpu_reset_n`=0, `ld_ready`=1 (state IDLE)
  - `busy`=0, `run_done`=0, `timeout`=0, `cycles`=0, `result`=0
- Reset mid-operation: identical to reset from idle; any partially loaded image is abandoned.
- Write latency:
  - A word accepted at edge N appears on `ext_we`=1/`ext_addr`/`ext_data` for the cycle after N.
  - Back-to-back acceptance gives one memory write per cycle.
  - `ext_we` drops the cycle after the last accepted word.
- `test_normal` falls one cycle after the final write cycle, so the last write completes with the external port selected.
- `cpu_reset_n` is low for exactly `RST_HOLD` cycles of HOLD, then rises at RUN entry.
- `cycles` counts RUN cycles including the cycle `cpu_done` is sampled. `cpu_done` high in the first RUN cycle gives `cycles`=1.
- TMO is entered when `cycles`=`TIMEOUT`.

## Structure
- Package `risc_boot_pkg`:
  - state enum
  - default widths (`AW`, `DW`)
  - `CYC_W`=16
- One sub-module, `sat_counter`: width-parameterised, with clear, enable and saturate/terminal-count flag. It is instantiated twice: hold counter and RUN cycle counter.
- FSM and output registers live in the top.

## Test plan
- Load 14 words (bench program at 0x0–0xB, data 0x47@0x25, 0x89@0x26; last flagged) → 14 single-cycle `ext_we` pulses with matching addr/data, then HOLD for 9 cycles, then RUN. `cpu_done` with `cpu_out`=16'hFFBE → DONE, `result`=FFBE.
- `ld_valid` gapped every other cycle → writes follow acceptance with 1-cycle latency, no extra or missing writes.
- `start` in IDLE with no load → HOLD/RUN directly. `start` during LOAD → ignored.
- `TIMEOUT`=8, `cpu_done` never asserted → TMO after `cycles`=8, `cpu_reset_n`=0. `cpu_done` at cycle 8 → DONE instead.
- `clear` in LOAD, HOLD and RUN → IDLE next cycle, `ext_we`=0, `cpu_reset_n`=0. `reset_n` low mid-RUN → all reset values.
